// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART-to-ALU frame assembler: state encoding,
// width defaults and ALU opcode values.
package uart_alu_interface_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    // States in which a frame is being executed or transmitted.
    function automatic logic is_busy_state(input logic [2:0] state);
        return (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT_TX);
    endfunction

endpackage

// File: rtl/uart_alu_interface_if.sv
// Bus bundle between the UART receiver/transmitter, the ALU and the frame assembler.
`default_nettype none

interface uart_alu_interface_if
    import uart_alu_interface_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
);
    logic               rx_done_tick;
    logic [NB_DATA-1:0] rx_data;
    logic [NB_DATA-1:0] alu_result;
    logic               tx_done_tick;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic               tx_start;
    logic [NB_DATA-1:0] tx_data;
    logic               busy;
    logic               timeout_tick;
    logic               rx_overrun;

    modport master (
        output rx_done_tick, rx_data, alu_result, tx_done_tick,
        input  o_data_a, o_data_b, o_op, tx_start, tx_data, busy, timeout_tick, rx_overrun
    );

    modport slave (
        input  rx_done_tick, rx_data, alu_result, tx_done_tick,
        output o_data_a, o_data_b, o_op, tx_start, tx_data, busy, timeout_tick, rx_overrun
    );
endinterface

`default_nettype wire

// File: rtl/uart_alu_interface_interbyte_timeout.sv
// Inter-byte idle counter: counts enabled cycles and flags expiry on the
// TIMEOUT-th one; TIMEOUT of 0 disables it entirely.
`default_nettype none

module interbyte_timeout #(
    parameter int TIMEOUT = 50000000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear_i,
    input  wire logic enable_i,
    output logic      expire_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT > 0) begin : g_counter
            logic [CNT_W-1:0] count_q;
            logic             expire_w;

            assign expire_w = enable_i && (count_q == CNT_W'(TIMEOUT - 1));
            assign expire_o = expire_w;

            always_ff @(posedge clk) begin
                if (rst || clear_i) begin
                    count_q <= '0;
                end else if (enable_i) begin
                    count_q <= expire_w ? '0 : count_q + 1'b1;
                end
            end
        end else begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clear_i, enable_i};
            assign expire_o      = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/uart_alu_interface.sv
// Assembles A/B/opcode frames from the UART receiver, captures the ALU result
// and hands it to the UART transmitter via a start/done handshake.
`default_nettype none

module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF,
    parameter int TIMEOUT = 50000000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    uart_alu_interface_if.slave bus
);

    logic [2:0]         state_q,        state_d;
    logic [NB_DATA-1:0] data_a_q,       data_a_d;
    logic [NB_DATA-1:0] data_b_q,       data_b_d;
    logic [NB_OP-1:0]   op_q,           op_d;
    logic [NB_DATA-1:0] tx_data_q,      tx_data_d;
    logic               timeout_tick_q, timeout_tick_d;
    logic               rx_overrun_q,   rx_overrun_d;

    logic in_window_w;
    logic tmr_enable_w;
    logic tmr_expire_w;

    // The idle counter only runs between bytes of a partially received frame.
    assign in_window_w  = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
    assign tmr_enable_w = in_window_w && !bus.rx_done_tick;

    interbyte_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (reset),
        .clear_i  (!tmr_enable_w),
        .enable_i (tmr_enable_w),
        .expire_o (tmr_expire_w)
    );

    always_comb begin
        state_d        = state_q;
        data_a_d       = data_a_q;
        data_b_d       = data_b_q;
        op_d           = op_q;
        tx_data_d      = tx_data_q;
        timeout_tick_d = 1'b0;
        rx_overrun_d   = rx_overrun_q;

        case (state_q)
            ST_WAIT_A: begin
                if (bus.rx_done_tick) begin
                    data_a_d = bus.rx_data;
                    state_d  = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (bus.rx_done_tick) begin
                    data_b_d = bus.rx_data;
                    state_d  = ST_WAIT_OP;
                end else if (tmr_expire_w) begin
                    state_d        = ST_WAIT_A;
                    timeout_tick_d = 1'b1;
                end
            end
            ST_WAIT_OP: begin
                if (bus.rx_done_tick) begin
                    op_d    = bus.rx_data[NB_OP-1:0];
                    state_d = ST_EXEC;
                end else if (tmr_expire_w) begin
                    state_d        = ST_WAIT_A;
                    timeout_tick_d = 1'b1;
                end
            end
            ST_EXEC: begin
                tx_data_d = bus.alu_result;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (bus.tx_done_tick) begin
                    state_d = ST_WAIT_A;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase

        // A byte arriving while a result is in flight is lost; remember that.
        if (bus.rx_done_tick && is_busy_state(state_q)) begin
            rx_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_WAIT_A;
            data_a_q       <= '0;
            data_b_q       <= '0;
            op_q           <= '0;
            tx_data_q      <= '0;
            timeout_tick_q <= 1'b0;
            rx_overrun_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            data_a_q       <= data_a_d;
            data_b_q       <= data_b_d;
            op_q           <= op_d;
            tx_data_q      <= tx_data_d;
            timeout_tick_q <= timeout_tick_d;
            rx_overrun_q   <= rx_overrun_d;
        end
    end

    assign bus.o_data_a     = data_a_q;
    assign bus.o_data_b     = data_b_q;
    assign bus.o_op         = op_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.timeout_tick = timeout_tick_q;
    assign bus.rx_overrun   = rx_overrun_q;
    assign bus.tx_start     = (state_q == ST_SEND);
    assign bus.busy         = is_busy_state(state_q);

endmodule

`default_nettype wire

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a small ALU model and TIMEOUT=10.
`default_nettype none

module tb_uart_alu_interface;
    import uart_alu_interface_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_alu_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    uart_alu_interface #(
        .NB_DATA (8),
        .NB_OP   (6),
        .TIMEOUT (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return $unsigned($signed(a) >>> b);
            OP_SRL:  return a >> b;
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    always_comb bus.alu_result = alu_model(bus.o_data_a, bus.o_data_b, bus.o_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_done_tick = 1'b1;
        bus.rx_data      = b;
        @(negedge clk);
        bus.rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        bus.tx_done_tick = 1'b1;
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_a"},       bus.o_data_a,     32'h0);
        check({tag, "_b"},       bus.o_data_b,     32'h0);
        check({tag, "_op"},      bus.o_op,         32'h0);
        check({tag, "_txdata"},  bus.tx_data,      32'h0);
        check({tag, "_txstart"}, bus.tx_start,     32'h0);
        check({tag, "_tick"},    bus.timeout_tick, 32'h0);
        check({tag, "_ovr"},     bus.rx_overrun,   32'h0);
        check({tag, "_busy"},    bus.busy,         32'h0);
        check({tag, "_state"},   dut.state_q,      32'(ST_WAIT_A));
    endtask

    // Sends a full frame, checks the result in the SEND cycle and completes the handshake.
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        @(negedge clk);
        check({tag, "_txstart"}, bus.tx_start, 32'h1);
        check({tag, "_txdata"},  bus.tx_data,  32'(exp));
        pulse_tx_done();
        check({tag, "_idle"}, bus.busy, 32'h0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
        bus.tx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("rst0");
        reset = 1'b0;

        // ADD frame with cycle-exact handshake timing
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        check("add_a",        bus.o_data_a, 32'h05);
        check("add_b",        bus.o_data_b, 32'h03);
        check("add_op",       bus.o_op,     32'h20);
        check("add_exec_st",  bus.tx_start, 32'h0);
        check("add_exec_bsy", bus.busy,     32'h1);
        @(negedge clk);
        check("add_send_st",  bus.tx_start, 32'h1);
        check("add_txdata",   bus.tx_data,  32'h08);
        @(negedge clk);
        check("add_wtx_st",   bus.tx_start, 32'h0);
        repeat (3) @(negedge clk);
        check("add_wtx_bsy",  bus.busy,     32'h1);
        check("add_wtx_data", bus.tx_data,  32'h08);
        pulse_tx_done();
        check("add_done_bsy", bus.busy,     32'h0);
        check("add_done_st",  dut.state_q,  32'(ST_WAIT_A));

        // Wrap-around subtraction, then a back-to-back OR frame
        run_frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
        run_frame("or",  8'hF0, 8'h0F, 8'h25, 8'hFF);

        // Timeout after 10 idle cycles in WAIT_B
        send_byte(8'h11);
        check("to_c1_tick", bus.timeout_tick, 32'h0);
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("to_c%0d_tick", i), bus.timeout_tick, 32'h0);
        end
        @(negedge clk);
        check("to_tick",     bus.timeout_tick, 32'h1);
        check("to_state",    dut.state_q,      32'(ST_WAIT_A));
        check("to_keep_a",   bus.o_data_a,     32'h11);
        @(negedge clk);
        check("to_tick_end", bus.timeout_tick, 32'h0);
        run_frame("post_to", 8'h01, 8'h02, 8'h20, 8'h03);

        // Second byte lands exactly in the expiry cycle
        send_byte(8'h11);
        repeat (8) @(negedge clk);
        send_byte(8'h22);
        check("edge_tick",  bus.timeout_tick, 32'h0);
        check("edge_state", dut.state_q,      32'(ST_WAIT_OP));
        check("edge_b",     bus.o_data_b,     32'h22);
        @(negedge clk);
        check("edge_tick2", bus.timeout_tick, 32'h0);
        send_byte(8'h20);
        @(negedge clk);
        check("edge_txdata", bus.tx_data, 32'h33);
        pulse_tx_done();

        // Overrun in WAIT_TX; opcode upper bits are dropped
        check("ovr_pre", bus.rx_overrun, 32'h0);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'hE0);
        check("ovr_op", bus.o_op, 32'h20);
        repeat (2) @(negedge clk);
        send_byte(8'h77);
        check("ovr_flag",  bus.rx_overrun, 32'h1);
        check("ovr_keepa", bus.o_data_a,   32'h10);
        check("ovr_busy",  bus.busy,       32'h1);
        check("ovr_state", dut.state_q,    32'(ST_WAIT_TX));
        check("ovr_txd",   bus.tx_data,    32'h30);
        pulse_tx_done();
        check("ovr_done",   dut.state_q,    32'(ST_WAIT_A));
        check("ovr_sticky", bus.rx_overrun, 32'h1);

        // Reset while in WAIT_OP
        send_byte(8'h05);
        send_byte(8'h06);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset("rst_op");

        // Reset while in WAIT_TX, then no stray tx_start
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h20);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset("rst_tx");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rst_tx_nostart%0d", i), bus.tx_start, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
